// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Memory-side arbiter between N_REQ cache read requesters, one write port
//   and a single memory. Read misses are queued in a DEPTH-entry circular
//   FIFO (any DEPTH >= 2). Writes bypass the FIFO and win over reads.
//   Memory responses are broadcast unchanged to every requester.
//
// Optional feature (compile-time macro MEM_ARB_MERGE_EN):
//   A pushed address that matches a valid FIFO entry or an earlier accepted
//   push of the same cycle is dropped. It is still acknowledged and takes
//   no slot, because the broadcast response serves it anyway.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_ren/raddr     per-requester read valid and address (slice i)
//   req_rready        per-requester accept strobe
//   wr_en/addr/line   write request, wr_ready = accept strobe
//   mem_ready         memory can take one request next cycle
//   mem_req_*         registered single-cycle read / write pulses to memory
//   mem_rec_*         memory response input
//   rec_*             combinational broadcast copy of mem_rec_*
//   occupancy         registered FIFO fill level
//
// Handshake: a transfer happens in a cycle where valid (req_ren[i] / wr_en)
// and ready (req_rready[i] / wr_ready) are both high. Ready never depends on
// the same requester's valid; a refused requester holds valid and retries.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_ren,
    input  logic [N_REQ*ADDR_W-1:0]   req_raddr,
    output logic [N_REQ-1:0]          req_rready,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [LINE_W-1:0]         wr_line,
    output logic                      wr_ready,
    input  logic                      mem_ready,
    output logic                      mem_req_ren,
    output logic [ADDR_W-1:0]         mem_req_raddr,
    output logic                      mem_req_wen,
    output logic [ADDR_W-1:0]         mem_req_waddr,
    output logic [LINE_W-1:0]         mem_req_wline,
    input  logic                      mem_rec_en,
    input  logic [ADDR_W-1:0]         mem_rec_addr,
    input  logic [LINE_W-1:0]         mem_rec_line,
    output logic                      rec_en,
    output logic [ADDR_W-1:0]         rec_addr,
    output logic [LINE_W-1:0]         rec_line,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] fifo_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [OCC_W-1:0]  occ_q;

    // Combinational push / issue decisions for the current cycle
    logic [N_REQ-1:0]  store;
    logic [PTR_W-1:0]  slot [N_REQ];
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] pop_addr;
    logic              do_write;
    logic              do_pop;
    int                n_store;

    // Pointer arithmetic modulo DEPTH; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int off);
        int sum;
        sum = (int'(base) + off) % DEPTH;
        return PTR_W'(sum);
    endfunction

    assign rec_en    = mem_rec_en;
    assign rec_addr  = mem_rec_addr;
    assign rec_line  = mem_rec_line;
    assign occupancy = occ_q;
    assign wr_ready  = mem_ready && !rst;

    always_comb begin
        int          free;
        int          seen;
        logic        dup;
        logic [ADDR_W-1:0] addr_i;
        free       = DEPTH - int'(occ_q);
        seen       = 0;
        n_store    = 0;
        req_rready = '0;
        store      = '0;
        first_addr = '0;
        dup        = 1'b0;
        addr_i     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            slot[i] = '0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            addr_i = req_raddr[i*ADDR_W +: ADDR_W];
            // Ready counts every higher-priority request, merged or not,
            // so it never depends on address contents.
            req_rready[i] = !rst && (free > seen);
            dup = 1'b0;
`ifdef MEM_ARB_MERGE_EN
            for (int k = 0; k < DEPTH; k++) begin
                if (k < int'(occ_q) && fifo_q[wrap_add(head_q, k)] == addr_i)
                    dup = 1'b1;
            end
            for (int j = 0; j < i; j++) begin
                if (req_ren[j] && req_rready[j] &&
                    req_raddr[j*ADDR_W +: ADDR_W] == addr_i)
                    dup = 1'b1;
            end
`endif
            if (req_ren[i] && req_rready[i] && !dup) begin
                store[i] = 1'b1;
                slot[i]  = wrap_add(tail_q, n_store);
                if (n_store == 0)
                    first_addr = addr_i;
                n_store = n_store + 1;
            end
            if (req_ren[i])
                seen = seen + 1;
        end

        do_write = wr_en && mem_ready;
        do_pop   = mem_ready && !do_write && (occ_q != '0 || n_store != 0);
        // With an empty FIFO the head entry is this cycle's first push.
        pop_addr = (occ_q != '0) ? fifo_q[head_q] : first_addr;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (store[i])
                fifo_q[slot[i]] <= req_raddr[i*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            occ_q         <= '0;
            mem_req_ren   <= 1'b0;
            mem_req_raddr <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_waddr <= '0;
            mem_req_wline <= '0;
        end else begin
            tail_q      <= wrap_add(tail_q, n_store);
            occ_q       <= occ_q + OCC_W'(n_store) - OCC_W'(do_pop);
            mem_req_ren <= do_pop;
            mem_req_wen <= do_write;
            if (do_pop) begin
                head_q        <= wrap_add(head_q, 1);
                mem_req_raddr <= pop_addr;
            end
            if (do_write) begin
                mem_req_waddr <= wr_addr;
                mem_req_wline <= wr_line;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A queue-based reference model
//   predicts ready strobes, memory request pulses and fill level each cycle.
//   Directed sequences cover reset, bypass, priority, backpressure, write
//   precedence and merge; a randomized phase follows.
//   Define MEM_ARB_MERGE_EN for both files to exercise the merge feature.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int N_REQ  = 2;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int OCC_W  = $clog2(DEPTH+1);

    logic                     clk;
    logic                     rst;
    logic [N_REQ-1:0]         req_ren;
    logic [N_REQ*ADDR_W-1:0]  req_raddr;
    logic [N_REQ-1:0]         req_rready;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [LINE_W-1:0]        wr_line;
    logic                     wr_ready;
    logic                     mem_ready;
    logic                     mem_req_ren;
    logic [ADDR_W-1:0]        mem_req_raddr;
    logic                     mem_req_wen;
    logic [ADDR_W-1:0]        mem_req_waddr;
    logic [LINE_W-1:0]        mem_req_wline;
    logic                     mem_rec_en;
    logic [ADDR_W-1:0]        mem_rec_addr;
    logic [LINE_W-1:0]        mem_rec_line;
    logic                     rec_en;
    logic [ADDR_W-1:0]        rec_addr;
    logic [LINE_W-1:0]        rec_line;
    logic [OCC_W-1:0]         occupancy;

    mem_arbiter #(
        .N_REQ(N_REQ), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_ren(req_ren), .req_raddr(req_raddr), .req_rready(req_rready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_line(wr_line), .wr_ready(wr_ready),
        .mem_ready(mem_ready),
        .mem_req_ren(mem_req_ren), .mem_req_raddr(mem_req_raddr),
        .mem_req_wen(mem_req_wen), .mem_req_waddr(mem_req_waddr),
        .mem_req_wline(mem_req_wline),
        .mem_rec_en(mem_rec_en), .mem_rec_addr(mem_rec_addr),
        .mem_rec_line(mem_rec_line),
        .rec_en(rec_en), .rec_addr(rec_addr), .rec_line(rec_line),
        .occupancy(occupancy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    int n_cmp = 0;
    int n_err = 0;
    logic [ADDR_W-1:0] exp_q[$];
    logic              exp_ren;
    logic [ADDR_W-1:0] exp_raddr;
    logic              exp_wen;
    logic [ADDR_W-1:0] exp_waddr;
    logic [LINE_W-1:0] exp_wline;
    logic [N_REQ-1:0]  last_acc;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic en, input logic [ADDR_W-1:0] a);
        req_ren[i] = en;
        req_raddr[i*ADDR_W +: ADDR_W] = a;
    endtask

    // One clock cycle: inputs are already driven. Checks combinational
    // outputs mid-cycle, advances the model, then checks registered outputs.
    task automatic step();
        int free;
        int seen;
        logic dup;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] acc_q[$];
        logic [ADDR_W-1:0] new_q[$];
        logic [N_REQ-1:0] exp_rdy;
        mem_rec_en   = 1'($urandom_range(0, 1));
        mem_rec_addr = $urandom;
        mem_rec_line = {$urandom, $urandom, $urandom, $urandom};
        #1;
        check("rec_en", 128'(rec_en), 128'(mem_rec_en));
        check("rec_addr", 128'(rec_addr), 128'(mem_rec_addr));
        check("rec_line", 128'(rec_line), 128'(mem_rec_line));

        exp_rdy = '0;
        if (!rst) begin
            free = DEPTH - exp_q.size();
            seen = 0;
            for (int i = 0; i < N_REQ; i++) begin
                exp_rdy[i] = (free > seen);
                if (req_ren[i]) begin
                    seen++;
                    if (exp_rdy[i]) begin
                        a = req_raddr[i*ADDR_W +: ADDR_W];
                        dup = 1'b0;
`ifdef MEM_ARB_MERGE_EN
                        foreach (exp_q[k]) if (exp_q[k] == a) dup = 1'b1;
                        foreach (acc_q[k]) if (acc_q[k] == a) dup = 1'b1;
`endif
                        acc_q.push_back(a);
                        if (!dup) new_q.push_back(a);
                    end
                end
            end
        end
        check("req_rready", 128'(req_rready), 128'(exp_rdy));
        check("wr_ready", 128'(wr_ready), 128'(!rst && mem_ready));
        last_acc = req_ren & exp_rdy;

        if (rst) begin
            exp_q.delete();
            exp_ren = 0; exp_raddr = '0; exp_wen = 0; exp_waddr = '0; exp_wline = '0;
        end else begin
            foreach (new_q[k]) exp_q.push_back(new_q[k]);
            exp_ren = 1'b0;
            exp_wen = wr_en && mem_ready;
            if (exp_wen) begin
                exp_waddr = wr_addr;
                exp_wline = wr_line;
            end else if (mem_ready && exp_q.size() > 0) begin
                exp_ren   = 1'b1;
                exp_raddr = exp_q.pop_front();
            end
        end

        @(posedge clk);
        #1;
        check("mem_req_ren", 128'(mem_req_ren), 128'(exp_ren));
        check("mem_req_raddr", 128'(mem_req_raddr), 128'(exp_raddr));
        check("mem_req_wen", 128'(mem_req_wen), 128'(exp_wen));
        check("mem_req_waddr", 128'(mem_req_waddr), 128'(exp_waddr));
        check("mem_req_wline", 128'(mem_req_wline), 128'(exp_wline));
        check("occupancy", 128'(occupancy), 128'(exp_q.size()));
    endtask

    task automatic idle_inputs();
        req_ren = '0;
        wr_en   = 1'b0;
    endtask

    logic              pend [N_REQ];
    logic [ADDR_W-1:0] paddr [N_REQ];

    initial begin
        rst = 1'b1; req_ren = '0; req_raddr = '0; wr_en = 1'b0; wr_addr = '0;
        wr_line = '0; mem_ready = 1'b1; mem_rec_en = 1'b0; mem_rec_addr = '0;
        mem_rec_line = '0;
        exp_ren = 0; exp_raddr = '0; exp_wen = 0; exp_waddr = '0; exp_wline = '0;
        last_acc = '0;
        @(posedge clk); #1;

        // Reset state, with requests and a write present during reset
        set_req(0, 1'b1, 32'h44); set_req(1, 1'b1, 32'h48); wr_en = 1'b1;
        step();
        step();
        check("reset_occ", 128'(occupancy), 128'(0));

        // Bypass: empty FIFO, one push, read issued one cycle later
        rst = 1'b0; idle_inputs(); mem_ready = 1'b1;
        set_req(0, 1'b1, 32'h40);
        step();
        check("bypass_ren", 128'(mem_req_ren), 128'(1));
        check("bypass_raddr", 128'(mem_req_raddr), 128'(32'h40));
        idle_inputs(); step();

        // Priority: both requesters in one cycle, index 0 issued first
        set_req(0, 1'b1, 32'h10); set_req(1, 1'b1, 32'h20);
        step();
        check("prio_first", 128'(mem_req_raddr), 128'(32'h10));
        idle_inputs(); step();
        check("prio_second", 128'(mem_req_raddr), 128'(32'h20));
        check("prio_second_ren", 128'(mem_req_ren), 128'(1));
        step();

        // Backpressure: memory stalled, five pushes, fifth refused
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_req(0, 1'b1, 32'h100 + 32'(k * 16));
            step();
        end
        check("bp_full", 128'(occupancy), 128'(DEPTH));
        check("bp_fifth_refused", 128'(last_acc), 128'(0));
        idle_inputs(); mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("bp_drain", 128'(mem_req_raddr), 128'(32'h100 + 32'(k * 16)));
        end
        step();

        // Write precedence over a queued read
        mem_ready = 1'b0; set_req(0, 1'b1, 32'h30);
        step();
        idle_inputs(); mem_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 32'h80; wr_line = 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa;
        step();
        check("wp_wen", 128'(mem_req_wen), 128'(1));
        check("wp_no_ren", 128'(mem_req_ren), 128'(0));
        wr_en = 1'b0;
        step();
        check("wp_read_after", 128'(mem_req_raddr), 128'(32'h30));
        check("wp_wen_low", 128'(mem_req_wen), 128'(0));

        // Duplicate address pushed twice while stalled
        mem_ready = 1'b0; set_req(0, 1'b1, 32'h50);
        step();
        step();
`ifdef MEM_ARB_MERGE_EN
        check("merge_occ", 128'(occupancy), 128'(1));
`else
        check("nomerge_occ", 128'(occupancy), 128'(2));
`endif
        idle_inputs(); mem_ready = 1'b1;
        step(); step(); step();

        // Reset mid-traffic with three entries queued
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, 32'h200 + 32'(k * 16));
            step();
        end
        check("rst_pre_occ", 128'(occupancy), 128'(3));
        rst = 1'b1; mem_ready = 1'b1; wr_en = 1'b1; set_req(1, 1'b1, 32'h300);
        step();
        check("rst_mid_occ", 128'(occupancy), 128'(0));
        check("rst_mid_ren", 128'(mem_req_ren), 128'(0));
        rst = 1'b0; idle_inputs(); step();

        // Randomized traffic; requesters hold until accepted
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = 1'b0; paddr[i] = '0;
        end
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    paddr[i] = 32'($urandom_range(1, 8) * 16);
                end
                set_req(i, pend[i], paddr[i]);
            end
            mem_ready = ($urandom_range(0, 9) < 6);
            wr_en     = ($urandom_range(0, 4) == 0);
            wr_addr   = $urandom;
            wr_line   = {$urandom, $urandom, $urandom, $urandom};
            rst       = ($urandom_range(0, 299) == 0);
            step();
            for (int i = 0; i < N_REQ; i++) begin
                if (last_acc[i]) pend[i] = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
